// File: rtl/md_ctrl.sv
// Multi-cycle multiply/divide sequencer for the E stage: launches one MD op per
// start pulse, holds busy for a fixed latency, then commits the result to HI/LO.
module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out,
    output logic [0:0]  state_dbg
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    logic [0:0]  state;
    logic [3:0]  cnt;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    logic        p_valid;

    logic        launch;
    logic        is_div;
    logic        div_signed;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] div_b_safe;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    // Handshake: start is a one-cycle launch pulse honoured only in IDLE with
    // md_op 1..4; busy is high from the launch edge until the commit/cancel
    // edge, and the issuing stage must not pulse start while busy is high.
    assign launch    = start && (md_op >= OP_MULT) && (md_op <= OP_DIVU);
    assign is_div    = (md_op == OP_DIV) || (md_op == OP_DIVU);
    assign state_dbg = state;

    // Signed product via sign-extended 64-bit operands keeps all math unsigned.
    assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign prod_u = {32'd0, rs} * {32'd0, rt};

    always_comb begin
        div_signed = (md_op == OP_DIV);
        div_a      = (div_signed && rs[31]) ? -rs : rs;
        div_b      = (div_signed && rt[31]) ? -rt : rt;
        div_b_safe = (rt == 32'd0) ? 32'd1 : div_b;
        uq         = div_a / div_b_safe;
        ur         = div_a % div_b_safe;
        quo        = (div_signed && (rs[31] ^ rt[31])) ? -uq : uq;
        rem        = (div_signed && rs[31]) ? -ur : ur;
        res_hi     = 32'd0;
        res_lo     = 32'd0;
        case (md_op)
            OP_MULT:          {res_hi, res_lo} = prod_s;
            OP_MULTU:         {res_hi, res_lo} = prod_u;
            OP_DIV, OP_DIVU: begin
                res_hi = rem;
                res_lo = quo;
            end
            default: ;
        endcase
    end

    always_comb begin
        md_out = 32'd0;
        if (md_op == OP_MFHI) md_out = hi;
        else if (md_op == OP_MFLO) md_out = lo;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            busy    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            p_hi    <= 32'd0;
            p_lo    <= 32'd0;
            p_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        p_hi    <= res_hi;
                        p_lo    <= res_lo;
                        // Divide by zero still occupies the unit but never commits.
                        p_valid <= !(is_div && (rt == 32'd0));
                        cnt     <= is_div ? DIV_LOAD : MULT_LOAD;
                        busy    <= 1'b1;
                        state   <= S_RUN;
                    end else if (md_op == OP_MTHI) begin
                        hi <= rs;
                    end else if (md_op == OP_MTLO) begin
                        lo <= rs;
                    end
                end
                S_RUN: begin
                    if (cancel) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (cnt == 4'd0) begin
                        if (p_valid) begin
                            hi <= p_hi;
                            lo <= p_lo;
                        end
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed scenarios plus random traffic,
// compared every cycle against an arithmetic reference model.
module tb_md_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;
    logic [0:0]  state_dbg;

    int n_checks;
    int n_pass;

    // Reference model state
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] m_phi;
    logic [31:0] m_plo;
    logic        m_pvalid;
    int          m_left;
    int          cur_n;
    int          busy_run;

    md_ctrl #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .rs       (rs),
        .rt       (rt),
        .cancel   (cancel),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .md_out   (md_out),
        .state_dbg(state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] model_md_out(input logic [3:0] op);
        if (op == 4'd5) return m_hi;
        if (op == 4'd6) return m_lo;
        return 32'd0;
    endfunction

    // Result of an MD op from plain 64-bit integer arithmetic.
    task automatic model_launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp, q, r;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        m_pvalid = 1'b1;
        m_phi = 32'd0;
        m_plo = 32'd0;
        case (op)
            4'd1: begin
                sp = sa * sb;
                {m_phi, m_plo} = sp;
                cur_n = MULT_N;
            end
            4'd2: begin
                up = longint'({32'd0, a}) * longint'({32'd0, b});
                {m_phi, m_plo} = up;
                cur_n = MULT_N;
            end
            4'd3: begin
                cur_n = DIV_N;
                if (b == 32'd0) m_pvalid = 1'b0;
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    m_plo = q[31:0];
                    m_phi = r[31:0];
                end
            end
            default: begin
                cur_n = DIV_N;
                if (b == 32'd0) m_pvalid = 1'b0;
                else begin
                    m_plo = a / b;
                    m_phi = a % b;
                end
            end
        endcase
        m_left = cur_n;
    endtask

    task automatic model_edge();
        if (m_left > 0) begin
            if (cancel) m_left = 0;
            else begin
                m_left--;
                if (m_left == 0 && m_pvalid) begin
                    m_hi = m_phi;
                    m_lo = m_plo;
                end
            end
        end else if (start && md_op >= 4'd1 && md_op <= 4'd4) begin
            model_launch(md_op, rs, rt);
        end else if (md_op == 4'd7) begin
            m_hi = rs;
        end else if (md_op == 4'd8) begin
            m_lo = rs;
        end
    endtask

    task automatic model_reset();
        m_hi = 32'd0;
        m_lo = 32'd0;
        m_left = 0;
        m_pvalid = 1'b0;
        busy_run = 0;
    endtask

    // Driver tasks
    task automatic drive(input logic st, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic cn);
        start  = st;
        md_op  = op;
        rs     = a;
        rt     = b;
        cancel = cn;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        chk("md_out", md_out, model_md_out(md_op));
        if (busy) busy_run++;
        else busy_run = 0;
        if (busy_run > cur_n) chk("busy_run_len", busy_run, cur_n);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        drive(1'b1, op, a, b, 1'b0);
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 20 && m_left > 0; i++) tick();
    endtask

    initial begin
        logic [31:0] save_hi, save_lo;
        logic [3:0]  op;
        n_checks = 0;
        n_pass   = 0;
        cur_n    = MULT_N;
        model_reset();
        reset = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        #12;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        #5 reset = 1'b1;

        // MULT -2 * 3
        run_op(4'd1, 32'hFFFF_FFFE, 32'd3);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        // DIVU then signed DIV
        run_op(4'd4, 32'd100, 32'd7);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        // MTHI then divide by zero
        drive(1'b0, 4'd7, 32'h1234, 32'd0, 1'b0);
        tick();
        run_op(4'd3, 32'd55, 32'd0);
        chk("div0_hi", hi, 32'h1234);
        drive(1'b0, 4'd5, 32'd0, 32'd0, 1'b0);
        #1 chk("mfhi", md_out, 32'h1234);
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        #1 chk("md_none", md_out, 32'd0);

        // MULTU cancelled on third busy cycle, MTLO ignored while busy
        save_hi = m_hi;
        save_lo = m_lo;
        drive(1'b1, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        tick();
        drive(1'b0, 4'd8, 32'd5, 32'd0, 1'b0);
        tick();
        drive(1'b0, 4'd8, 32'd5, 32'd0, 1'b1);
        tick();
        chk("cancel_busy", {31'd0, busy}, 32'd0);
        chk("cancel_hi", hi, save_hi);
        chk("cancel_lo", lo, save_lo);
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        tick();

        // Asynchronous reset in the middle of a DIV
        drive(1'b1, 4'd4, 32'd1000, 32'd3, 1'b0);
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("areset_busy", {31'd0, busy}, 32'd0);
        chk("areset_hi", hi, 32'd0);
        chk("areset_lo", lo, 32'd0);
        #3 reset = 1'b1;
        run_op(4'd1, 32'd6, 32'd7);
        chk("mult67_lo", lo, 32'd42);

        // Back-to-back: mult, div, mult with launches on the falling-busy cycle
        run_op(4'd1, 32'd1000, 32'hFFFF_FFFD);
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'd0);
        run_op(4'd1, 32'h0001_0000, 32'h0001_0000);
        chk("b2b_hi", hi, 32'd1);
        chk("b2b_lo", lo, 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(0, 15));
            drive((op == 4'd7 || op == 4'd8) ? 1'b0 : 1'($urandom_range(0, 1)), op,
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom(),
                  ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 3)) : $urandom(),
                  ($urandom_range(0, 9) == 0));
            tick();
        end
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 20 && m_left > 0; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
